// File: rtl/des_key_sequencer.sv
// Iterative DES key schedule: one PC-1 at load, one 56-bit C/D register rotated per round,
// one PC-2 on the output. Emits K1..K16 (encrypt) or K16..K1 (decrypt), one per handshake.

module Permuted_Choice_1 (
    input  logic [63:0] key_i,
    output logic [55:0] cd_o
);
    localparam int unsigned PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    // DES numbers bits MSB-first: DES bit n lives at key_i[64-n].
    for (genvar g = 0; g < 56; g++) begin : g_pc1
        assign cd_o[55-g] = key_i[64-PC1_TAB[g]];
    end

    logic unused_parity;
    assign unused_parity = ^{key_i[56], key_i[48], key_i[40], key_i[32],
                             key_i[24], key_i[16], key_i[8],  key_i[0]};
endmodule

module Permuted_Choice_2 (
    input  logic [55:0] cd_i,
    output logic [47:0] k_o
);
    localparam int unsigned PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    for (genvar g = 0; g < 48; g++) begin : g_pc2
        assign k_o[47-g] = cd_i[56-PC2_TAB[g]];
    end

    logic unused_dropped;
    assign unused_dropped = ^{cd_i[47], cd_i[38], cd_i[34], cd_i[31],
                              cd_i[21], cd_i[18], cd_i[13], cd_i[2]};
endmodule

module des_key_sequencer #(
    parameter bit CHECK_PARITY = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [63:0] key_in_i,
    input  logic        key_valid_i,
    output logic        key_ready_o,
    input  logic        decrypt_i,
    input  logic        abort_i,
    output logic [47:0] subkey_o,
    output logic [3:0]  subkey_idx_o,
    output logic        subkey_valid_o,
    input  logic        subkey_ready_i,
    output logic        subkey_last_o,
    output logic        busy_o,
    output logic        parity_err_o
);
    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t      state_q, state_d;
    logic [55:0] cd_q, cd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        mode_q, mode_d;
    logic        perr_q, perr_d;

    logic [55:0] cd0;
    logic        key_bad;
    logic        one_shift;

    function automatic logic [27:0] rotl28(input logic [27:0] v, input logic two);
        return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] v, input logic two);
        return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
    endfunction

    Permuted_Choice_1 u_pc1 (.key_i(key_in_i), .cd_o(cd0));
    Permuted_Choice_2 u_pc2 (.cd_i(cd_q), .k_o(subkey_o));

    always_comb begin
        key_bad = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (~^key_in_i[8*b +: 8]) key_bad = 1'b1;
        end
    end

    // Single-bit steps fall after rounds 1, 8 and 15 in both directions:
    // encrypt uses S[cnt+2], decrypt uses S[16-cnt]; cnt=15 never advances.
    assign one_shift = (cnt_q == 4'd0) || (cnt_q == 4'd7) || (cnt_q == 4'd14);

    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        perr_d  = perr_q;
        if (abort_i) begin
            state_d = ST_IDLE;
            cd_d    = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (key_valid_i) begin
                        if (CHECK_PARITY && key_bad) begin
                            perr_d = 1'b1;
                        end else begin
                            perr_d  = 1'b0;
                            mode_d  = decrypt_i;
                            cnt_d   = '0;
                            cd_d    = decrypt_i ? cd0
                                                : {rotl28(cd0[55:28], 1'b0), rotl28(cd0[27:0], 1'b0)};
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (subkey_ready_i) begin
                        if (cnt_q == 4'd15) begin
                            state_d = ST_IDLE;
                            cd_d    = '0;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                            cd_d  = mode_q
                                ? {rotr28(cd_q[55:28], !one_shift), rotr28(cd_q[27:0], !one_shift)}
                                : {rotl28(cd_q[55:28], !one_shift), rotl28(cd_q[27:0], !one_shift)};
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cd_q    <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            perr_q  <= perr_d;
        end
    end

    assign key_ready_o    = (state_q == ST_IDLE);
    assign subkey_valid_o = (state_q == ST_RUN);
    assign busy_o         = (state_q == ST_RUN);
    assign subkey_last_o  = (state_q == ST_RUN) && (cnt_q == 4'd15);
    assign subkey_idx_o   = mode_q ? ~cnt_q : cnt_q;
    assign parity_err_o   = perr_q;
endmodule

// File: tb/tb_des_key_sequencer.sv
// Bench for des_key_sequencer: transaction-level key-schedule model checked every cycle,
// directed DES example vectors, and a randomized soak.

module tb_des_key_sequencer;
    localparam logic [63:0] KEX  = 64'h133457799BBCDFF1;
    localparam logic [47:0] KEX1 = 48'h1B02EFFC7072;
    localparam logic [47:0] KEX16 = 48'hCB3D8B0E17F5;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic        clk = 1'b0;
    logic        reset, key_valid, decrypt, abort, subkey_ready;
    logic [63:0] key_in;
    logic        key_ready, subkey_valid, subkey_last, busy, parity_err;
    logic [47:0] subkey;
    logic [3:0]  subkey_idx;

    logic        np_reset, np_key_valid, np_decrypt, np_abort, np_subkey_ready;
    logic [63:0] np_key_in;
    logic        np_key_ready, np_subkey_valid, np_subkey_last, np_busy, np_parity_err;
    logic [47:0] np_subkey;
    logic [3:0]  np_subkey_idx;

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    // Model state: whether a schedule is running, which position of 16 is on the output.
    logic        m_run = 1'b0;
    int          m_pos = 0;
    logic        m_perr = 1'b0;
    logic        m_dec = 1'b0;
    logic [63:0] m_key = '0;

    always #5 clk = ~clk;

    des_key_sequencer #(.CHECK_PARITY(1'b1)) dut (
        .clk_i(clk), .reset_i(reset), .key_in_i(key_in), .key_valid_i(key_valid),
        .key_ready_o(key_ready), .decrypt_i(decrypt), .abort_i(abort),
        .subkey_o(subkey), .subkey_idx_o(subkey_idx), .subkey_valid_o(subkey_valid),
        .subkey_ready_i(subkey_ready), .subkey_last_o(subkey_last), .busy_o(busy),
        .parity_err_o(parity_err)
    );

    des_key_sequencer #(.CHECK_PARITY(1'b0)) dut_np (
        .clk_i(clk), .reset_i(np_reset), .key_in_i(np_key_in), .key_valid_i(np_key_valid),
        .key_ready_o(np_key_ready), .decrypt_i(np_decrypt), .abort_i(np_abort),
        .subkey_o(np_subkey), .subkey_idx_o(np_subkey_idx), .subkey_valid_o(np_subkey_valid),
        .subkey_ready_i(np_subkey_ready), .subkey_last_o(np_subkey_last), .busy_o(np_busy),
        .parity_err_o(np_parity_err)
    );

    // Subkey Kn straight from the textbook definition: PC1, cumulative left shifts, PC2.
    function automatic logic [47:0] model_subkey(input logic [63:0] key, input int n);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] k;
        int sh;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
        c = cd[55:28];
        d = cd[27:0];
        sh = 0;
        for (int r = 0; r < n; r++) sh += SHIFTS[r];
        for (int s = 0; s < sh; s++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2_T[i]];
        return k;
    endfunction

    function automatic logic bad_parity(input logic [63:0] k);
        for (int b = 0; b < 8; b++) begin
            if ($countones(k[8*b +: 8]) % 2 == 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [63:0] make_odd(input logic [63:0] k);
        logic [63:0] r;
        r = k;
        for (int b = 0; b < 8; b++) begin
            if ($countones(r[8*b +: 8]) % 2 == 0) r[8*b] = ~r[8*b];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_run  <= 1'b0;
            m_pos  <= 0;
            m_perr <= 1'b0;
            m_dec  <= 1'b0;
        end else if (abort) begin
            m_run <= 1'b0;
            m_pos <= 0;
        end else if (!m_run) begin
            if (key_valid) begin
                if (bad_parity(key_in)) begin
                    m_perr <= 1'b1;
                end else begin
                    m_perr <= 1'b0;
                    m_run  <= 1'b1;
                    m_pos  <= 0;
                    m_key  <= key_in;
                    m_dec  <= decrypt;
                end
            end
        end else if (subkey_ready) begin
            if (m_pos == 15) begin
                m_run <= 1'b0;
                m_pos <= 0;
            end else begin
                m_pos <= m_pos + 1;
            end
        end
    end

    always @(negedge clk) begin
        int n;
        if (chk_en) begin
            check("key_ready", 64'(key_ready), 64'(!m_run));
            check("subkey_valid", 64'(subkey_valid), 64'(m_run));
            check("busy", 64'(busy), 64'(m_run));
            check("subkey_last", 64'(subkey_last), 64'(m_run && m_pos == 15));
            check("parity_err", 64'(parity_err), 64'(m_perr));
            if (m_run) begin
                n = m_dec ? 16 - m_pos : m_pos + 1;
                check("subkey", 64'(subkey), 64'(model_subkey(m_key, n)));
                check("subkey_idx", 64'(subkey_idx), 64'(n - 1));
            end else begin
                check("subkey_idle", 64'(subkey), 64'(0));
            end
        end
    end

    task automatic wait_idx(input int target, input string name);
        logic found;
        found = 1'b0;
        for (int t = 0; t < 64; t++) begin
            if (m_run && ((m_dec ? 15 - m_pos : m_pos) == target)) begin
                found = 1'b1;
                break;
            end
            cyc();
        end
        check(name, 64'(found), 64'(1));
    endtask

    task automatic wait_idle(input string name);
        for (int t = 0; t < 64; t++) begin
            if (!m_run) break;
            cyc();
        end
        check(name, 64'(key_ready), 64'(1));
    endtask

    task automatic load_key(input logic [63:0] k, input logic dec);
        key_in    = k;
        decrypt   = dec;
        key_valid = 1'b1;
        cyc();
        key_valid = 1'b0;
    endtask

    initial begin
        logic        held;
        logic [63:0] k;
        reset = 1'b1; abort = 1'b0; key_valid = 1'b0; decrypt = 1'b0;
        subkey_ready = 1'b0; key_in = '0;
        np_reset = 1'b1; np_abort = 1'b0; np_key_valid = 1'b0; np_decrypt = 1'b0;
        np_subkey_ready = 1'b1; np_key_in = '0;
        repeat (2) cyc();
        chk_en = 1'b1;
        check("rst_key_ready", 64'(key_ready), 64'(1));
        check("rst_valid", 64'(subkey_valid), 64'(0));
        check("rst_idx", 64'(subkey_idx), 64'(0));
        check("rst_subkey", 64'(subkey), 64'(0));
        reset = 1'b0;
        np_reset = 1'b0;
        cyc();

        check("model_K1", 64'(model_subkey(KEX, 1)), 64'(KEX1));
        check("model_K16", 64'(model_subkey(KEX, 16)), 64'(KEX16));

        // Encrypt order, consumer always ready.
        subkey_ready = 1'b1;
        load_key(KEX, 1'b0);
        check("enc_first", 64'(subkey), 64'(KEX1));
        check("enc_first_idx", 64'(subkey_idx), 64'(0));
        repeat (15) cyc();
        check("enc_last", 64'(subkey), 64'(KEX16));
        check("enc_last_idx", 64'(subkey_idx), 64'(15));
        check("enc_last_flag", 64'(subkey_last), 64'(1));
        cyc();
        check("enc_idle_valid", 64'(subkey_valid), 64'(0));
        check("enc_idle_ready", 64'(key_ready), 64'(1));

        // Decrypt order.
        load_key(KEX, 1'b1);
        check("dec_first", 64'(subkey), 64'(KEX16));
        check("dec_first_idx", 64'(subkey_idx), 64'(15));
        repeat (15) cyc();
        check("dec_last", 64'(subkey), 64'(KEX1));
        check("dec_last_idx", 64'(subkey_idx), 64'(0));
        check("dec_last_flag", 64'(subkey_last), 64'(1));
        cyc();

        // Back-pressure: random ready, held low 5 cycles at idx 7.
        subkey_ready = 1'($urandom_range(0, 1));
        load_key(KEX, 1'b0);
        held = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (!m_run) break;
            if (!held && m_pos == 7) begin
                subkey_ready = 1'b0;
                repeat (5) begin
                    cyc();
                    check("stall_idx", 64'(subkey_idx), 64'(7));
                end
                held = 1'b1;
            end
            subkey_ready = 1'($urandom_range(0, 1));
            cyc();
        end
        check("stall_done", 64'(key_ready), 64'(1));
        check("stall_held", 64'(held), 64'(1));

        // Parity rejection, then a good key clears the flag.
        subkey_ready = 1'b1;
        key_in = '0;
        key_valid = 1'b1;
        repeat (3) begin
            cyc();
            check("par_err", 64'(parity_err), 64'(1));
            check("par_key_ready", 64'(key_ready), 64'(1));
            check("par_no_valid", 64'(subkey_valid), 64'(0));
        end
        load_key(KEX, 1'b0);
        check("par_cleared", 64'(parity_err), 64'(0));
        wait_idle("par_run_idle");
        cyc();

        // Abort at idx 4 with a simultaneous key offer.
        load_key(make_odd({$urandom(), $urandom()}), 1'b0);
        wait_idx(4, "abort_reach_idx4");
        abort = 1'b1;
        key_valid = 1'b1;
        key_in = make_odd({$urandom(), $urandom()});
        cyc();
        abort = 1'b0;
        key_valid = 1'b0;
        check("abort_valid", 64'(subkey_valid), 64'(0));
        check("abort_key_ready", 64'(key_ready), 64'(1));
        load_key(KEX, 1'b0);
        check("post_abort_first", 64'(subkey), 64'(KEX1));
        wait_idle("post_abort_idle");
        cyc();

        // key_valid during RUN ignored, then reset+abort at idx 9.
        load_key(KEX, 1'b1);
        key_valid = 1'b1;
        key_in = make_odd({$urandom(), $urandom()});
        wait_idx(9, "reset_reach_idx9");
        reset = 1'b1;
        abort = 1'b1;
        key_valid = 1'b0;
        cyc();
        reset = 1'b0;
        abort = 1'b0;
        check("mid_rst_key_ready", 64'(key_ready), 64'(1));
        check("mid_rst_valid", 64'(subkey_valid), 64'(0));
        check("mid_rst_last", 64'(subkey_last), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_idx", 64'(subkey_idx), 64'(0));
        check("mid_rst_subkey", 64'(subkey), 64'(0));
        cyc();

        // Randomized soak.
        for (int t = 0; t < 2500; t++) begin
            k = make_odd({$urandom(), $urandom()});
            if ($urandom_range(0, 3) == 0) k[$urandom_range(0, 63)] ^= 1'b1;
            key_in       = k;
            key_valid    = ($urandom_range(0, 2) == 0);
            decrypt      = 1'($urandom_range(0, 1));
            subkey_ready = ($urandom_range(0, 3) != 0);
            abort        = ($urandom_range(0, 59) == 0);
            reset        = ($urandom_range(0, 199) == 0);
            cyc();
        end
        reset = 1'b0; abort = 1'b0; key_valid = 1'b0; subkey_ready = 1'b1;
        wait_idle("soak_idle");

        // Parity check disabled: all-zero key accepted, schedule all zero.
        np_key_in = '0;
        np_decrypt = 1'b0;
        np_key_valid = 1'b1;
        cyc();
        np_key_valid = 1'b0;
        for (int j = 0; j < 16; j++) begin
            check("np_zero_valid", 64'(np_subkey_valid), 64'(1));
            check("np_zero_busy", 64'(np_busy), 64'(1));
            check("np_zero_subkey", 64'(np_subkey), 64'(0));
            check("np_zero_idx", 64'(np_subkey_idx), 64'(j));
            cyc();
        end
        check("np_zero_done", 64'(np_key_ready), 64'(1));
        check("np_perr", 64'(np_parity_err), 64'(0));

        // Even-parity variant of the example key, decrypt order.
        np_key_in = KEX ^ 64'h1;
        np_decrypt = 1'b1;
        np_key_valid = 1'b1;
        cyc();
        np_key_valid = 1'b0;
        for (int j = 0; j < 16; j++) begin
            check("np_dec_subkey", 64'(np_subkey), 64'(model_subkey(KEX ^ 64'h1, 16 - j)));
            check("np_dec_idx", 64'(np_subkey_idx), 64'(15 - j));
            check("np_dec_last", 64'(np_subkey_last), 64'(j == 15));
            cyc();
        end
        check("np_dec_done", 64'(np_key_ready), 64'(1));

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
